// File: rtl/vga_frame_sequencer.sv
// VGA timing generator with a tiled playfield and a double-buffered falling-piece overlay.
// Pixel pipeline: counters -> stage 1 (map address, piece hit) -> stage 2 (colour, syncs).
module vga_frame_sequencer #(
  parameter int BLOCK_W   = 17,
  parameter int BOARD_X0  = 235,
  parameter int BOARD_Y0  = 70,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] piece_x,
  input  logic [19:0] piece_y,
  input  logic        piece_load,
  output logic [7:0]  map_addr,
  input  logic        map_data,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_tick
);

  localparam logic [9:0] L_H_MAX  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] L_V_MAX  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] L_H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] L_V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] L_HS_ON  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] L_HS_OFF = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] L_VS_ON  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] L_VS_OFF = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] L_X0     = 10'(BOARD_X0);
  localparam logic [9:0] L_X1     = 10'(BOARD_X0 + 10 * BLOCK_W);
  localparam logic [9:0] L_Y0     = 10'(BOARD_Y0);
  localparam logic [9:0] L_Y1     = 10'(BOARD_Y0 + 20 * BLOCK_W);
  localparam logic [4:0] L_SUB_MAX = 5'(BLOCK_W - 1);

  function automatic logic in_x(input logic [9:0] h);
    return (h >= L_X0) && (h < L_X1);
  endfunction

  function automatic logic in_y(input logic [9:0] v);
    return (v >= L_Y0) && (v < L_Y1);
  endfunction

  logic [1:0]  r_pre;
  logic [9:0]  r_hcount, r_vcount;
  logic [3:0]  r_col;
  logic [4:0]  r_hsub, r_row, r_vsub;
  logic [15:0] r_shadow_x, r_act_x;
  logic [19:0] r_shadow_y, r_act_y;
  logic        r_pend, r_frame_tick;
  logic        r_s1_vis, r_s1_hs, r_s1_vs, r_s1_inb, r_s1_hit;
  logic [7:0]  r_map_addr;
  logic        r_hs, r_vs;
  logic [3:0]  r_r, r_g, r_b;

  logic        w_pix_ce, w_h_wrap, w_xfer, w_in_board, w_piece_hit;
  logic [9:0]  w_h_nxt, w_v_nxt;
  logic [7:0]  w_addr;

  assign w_pix_ce = (r_pre == 2'd3);
  assign w_h_wrap = (r_hcount == L_H_MAX);
  assign w_h_nxt  = w_h_wrap ? 10'd0 : r_hcount + 10'd1;
  assign w_v_nxt  = (r_vcount == L_V_MAX) ? 10'd0 : r_vcount + 10'd1;
  // Fires on the tick that moves the beam to the first blanking line.
  assign w_xfer   = w_pix_ce && w_h_wrap && (r_vcount == L_V_VIS - 10'd1);
  assign w_in_board = in_x(r_hcount) && in_y(r_vcount);
  assign w_addr   = {r_row, 3'b000} + {2'b00, r_row, 1'b0} + {4'b0000, r_col};

  always_comb begin
    w_piece_hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if ((r_act_x[4*k +: 4] == r_col) && (r_act_y[5*k +: 5] == r_row) &&
          (r_act_x[4*k +: 4] <= 4'd9) && (r_act_y[5*k +: 5] <= 5'd19))
        w_piece_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pre <= 2'd0;
    else        r_pre <= r_pre + 2'd1;
  end

  // Cell counters follow the beam incrementally and hold still outside the board.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount <= '0; r_vcount <= '0;
      r_col <= '0; r_hsub <= '0; r_row <= '0; r_vsub <= '0;
    end else if (w_pix_ce) begin
      r_hcount <= w_h_nxt;
      if (w_h_nxt == L_X0) begin
        r_col <= '0; r_hsub <= '0;
      end else if (in_x(w_h_nxt)) begin
        if (r_hsub == L_SUB_MAX) begin
          r_hsub <= '0; r_col <= r_col + 4'd1;
        end else begin
          r_hsub <= r_hsub + 5'd1;
        end
      end
      if (w_h_wrap) begin
        r_vcount <= w_v_nxt;
        if (w_v_nxt == L_Y0) begin
          r_row <= '0; r_vsub <= '0;
        end else if (in_y(w_v_nxt)) begin
          if (r_vsub == L_SUB_MAX) begin
            r_vsub <= '0; r_row <= r_row + 5'd1;
          end else begin
            r_vsub <= r_vsub + 5'd1;
          end
        end
      end
    end
  end

  // A load on the transfer clock bypasses the shadow so the newest piece wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_x <= '0; r_shadow_y <= '0;
      r_act_x <= '0; r_act_y <= '0;
      r_pend <= 1'b0; r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_xfer;
      if (piece_load) begin
        r_shadow_x <= piece_x; r_shadow_y <= piece_y;
      end
      if (w_xfer) begin
        r_pend <= 1'b0;
        if (piece_load) begin
          r_act_x <= piece_x; r_act_y <= piece_y;
        end else if (r_pend) begin
          r_act_x <= r_shadow_x; r_act_y <= r_shadow_y;
        end
      end else if (piece_load) begin
        r_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vis <= 1'b0; r_s1_hs <= 1'b1; r_s1_vs <= 1'b1;
      r_s1_inb <= 1'b0; r_s1_hit <= 1'b0; r_map_addr <= '0;
      r_hs <= 1'b1; r_vs <= 1'b1; r_r <= '0; r_g <= '0; r_b <= '0;
    end else if (w_pix_ce) begin
      r_s1_vis   <= (r_hcount < L_H_VIS) && (r_vcount < L_V_VIS);
      r_s1_hs    <= !((r_hcount >= L_HS_ON) && (r_hcount < L_HS_OFF));
      r_s1_vs    <= !((r_vcount >= L_VS_ON) && (r_vcount < L_VS_OFF));
      r_s1_inb   <= w_in_board;
      r_s1_hit   <= w_in_board && w_piece_hit;
      r_map_addr <= w_in_board ? w_addr : 8'd0;
      r_hs <= r_s1_hs;
      r_vs <= r_s1_vs;
      if (!r_s1_vis) begin
        r_r <= 4'h0; r_g <= 4'h0; r_b <= 4'h0;
      end else if (r_s1_hit) begin
        r_r <= 4'hF; r_g <= 4'hF; r_b <= 4'hF;
      end else if (r_s1_inb) begin
        r_r <= map_data ? 4'h8 : 4'h0;
        r_g <= map_data ? 4'h8 : 4'h0;
        r_b <= map_data ? 4'h8 : 4'h0;
      end else begin
        r_r <= 4'h0; r_g <= 4'h8; r_b <= 4'h0;
      end
    end
  end

  assign map_addr   = r_map_addr;
  assign vga_hs     = r_hs;
  assign vga_vs     = r_vs;
  assign vga_r      = r_r;
  assign vga_g      = r_g;
  assign vga_b      = r_b;
  assign frame_tick = r_frame_tick;

endmodule

// File: doc/vga_frame_sequencer.md
VGA_FRAME_SEQUENCER -- requirements
Module: vga_frame_sequencer

Interface
REQ-001 SHALL have parameter BLOCK_W, default 17, meaning cell edge in pixels.
REQ-002 SHALL have parameter BOARD_X0, default 235, meaning board left edge pixel column.
REQ-003 SHALL have parameter BOARD_Y0, default 70, meaning board top edge pixel row.
REQ-004 SHALL have port clk, input, 1, meaning 100 MHz system clock; one clock only.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port piece_x, input, 16, meaning four 4-bit block columns; block k at bits [4k+3:4k].
REQ-007 SHALL have port piece_y, input, 20, meaning four 5-bit block rows; block k at bits [5k+4:5k].
REQ-008 SHALL have port piece_load, input, 1, meaning a single-cycle strobe that captures piece_x/piece_y.
REQ-009 SHALL have port map_addr, output, 8, meaning playfield RAM address = row*10+col.
REQ-010 SHALL have port map_data, input, 1, meaning cell occupied; valid one clk after map_addr.
REQ-011 SHALL have ports vga_hs and vga_vs, output, 1 each, meaning syncs, active-low.
REQ-012 SHALL have ports vga_r, vga_g and vga_b, output, 4 each, meaning pixel colour.
REQ-013 SHALL have port frame_tick, output, 1, meaning one-clk pulse at vblank start.

Function
REQ-014 SHALL generate pix_ce on every 4th clk using a 2-bit prescaler; all timing state SHALL advance only on pix_ce.
REQ-015 SHALL run hcount 0..799 and vcount 0..524; hcount wrap SHALL increment vcount, and vcount SHALL wrap 524->0.
REQ-016 SHALL define raw hs as low for hcount 656..751, raw vs as low for vcount 490..491, and visible as hcount<640 && vcount<480.
REQ-017 SHALL track the current cell with incrementing col/sub-pixel counters (sub 0..BLOCK_W-1), not division; board region = 10x20 cells from (BOARD_X0,BOARD_Y0).
REQ-018 SHALL use counters that reset at hcount==BOARD_X0 (col) and vcount==BOARD_Y0 (row), and SHALL freeze them outside the region.
REQ-019 SHALL register map_addr in stage 1, to row*10+col inside the region and to 0 outside it.
REQ-020 SHALL register colour in stage 2 by priority: not visible -> 0,0,0; piece cell -> F,F,F; map_data=1 -> 8,8,8; board empty -> 0,0,0; outside board -> 0,8,0.
REQ-021 SHALL delay hs, vs and visible through the same 2 pix_ce stages, so that all VGA outputs align, with a total latency of 2 pix_ce ticks (8 clk) from counter to pins.
REQ-022 SHALL treat a piece block as matching when its (x,y) equals the current (col,row) and the pixel is inside the board.
REQ-023 SHALL never draw a block with x>9 or y>19, and SHALL NOT allow such a block to alias into other cells.
REQ-024 SHALL capture piece_load into a shadow register and set a pending flag.
REQ-025 SHALL copy shadow to active and clear pending on the pix_ce where vcount becomes 480 with hcount 0; frame_tick SHALL pulse on that same clk.
REQ-026 SHALL keep active piece registers unchanged during visible lines, with no tearing.
REQ-027 SHALL, when piece_load coincides with the transfer clk, transfer the newly presented values to active, leaving pending cleared.
REQ-028 SHALL, on multiple piece_load strobes within one frame, keep only the last one.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear prescaler, hcount, vcount, cell counters, pipeline, shadow, active (all blocks at 0,0), pending, map_addr and RGB.
REQ-030 SHALL drive vga_hs=1, vga_vs=1 and frame_tick=0 during reset.
REQ-031 SHALL, after rst_n rises, start the first pix_ce 4 clk later with counting from (0,0).
REQ-032 SHALL, on reset mid-frame, abort the frame and lose any pending piece.

Verification
REQ-033 SHALL be verified by a sync timing check: free-run 2 frames -> vga_hs low 96 pix_ce per 800-tick line, vga_vs low exactly 2 lines per 525-line frame, both offset by 2-tick latency.
REQ-034 SHALL be verified by a map address check: hcount=235,vcount=70 -> map_addr=0; hcount=405-1,vcount=409 -> map_addr=199; hcount=252,vcount=70 -> map_addr=1.
REQ-035 SHALL be verified by a piece overlay check: piece_load with block0=(0,0), wait frame_tick -> next frame pixel (235,70) RGB=F,F,F; with map_data=1 at addr 5 -> pixel (320,70) RGB=8,8,8.
REQ-036 SHALL be verified by a double-buffer check: piece_load mid-visible frame -> current frame unchanged, new piece shown from following frame; piece_load on transfer clk -> shown next frame.
REQ-037 SHALL be verified by an out-of-range check: block x=12,y=3 -> no F,F,F pixels anywhere; outside board visible -> 0,8,0.
REQ-038 SHALL be verified by a reset mid-frame check: assert rst_n low at vcount=200 -> outputs at reset values immediately; after release, first hs low at pix_ce tick 656+2.
